// File: rtl/round_sequencer_pkg.sv
// rtl/round_sequencer_pkg.sv - shared prompt codes, state encoding and LFSR step for round_sequencer
package round_sequencer_pkg;

  localparam logic [2:0] PR_NONE   = 3'd0;
  localparam logic [2:0] PR_TOGGLE = 3'd1;
  localparam logic [2:0] PR_PUSH   = 3'd2;
  localparam logic [2:0] PR_MIC    = 3'd3;
  localparam logic [2:0] PR_MOUSE  = 3'd4;
  localparam logic [2:0] PR_WIN    = 3'd5;
  localparam logic [2:0] PR_LOSE   = 3'd6;

  typedef enum logic [2:0] {
    IDLE, GEN, SHOW_ON, SHOW_OFF, LISTEN, WIN, LOSE, OVER
  } state_t;

  // x^8+x^6+x^5+x^4+1 -> taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/round_sequencer_tick_gen.sv
// rtl/round_sequencer_tick_gen.sv - free-running divider producing a one-cycle tick every TICK_DIV clocks
module tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     cnt <= '0;
    else if (tick)  cnt <= '0;
    else            cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - game-round controller: generate, play back and check move patterns
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int         MAX_LEN       = 8,
  parameter int         START_LEN     = 2,
  parameter int         LIVES         = 3,
  parameter int         TICK_DIV      = 25000000,
  parameter int         SHOW_TICKS    = 2,
  parameter int         TIMEOUT_TICKS = 8,
  parameter int         FB_TICKS      = 2,
  parameter logic [7:0] SEED          = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       toggle_evt,
  input  logic       push_evt,
  input  logic       mic_evt,
  input  logic       mouse_evt,
  output logic [2:0] prompt,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [3:0] round_len,
  output logic       listening,
  output logic       game_over
);

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  state_t     state, state_n;
  logic [7:0] lfsr, lfsr_n;
  logic [1:0] pattern [MAX_LEN];
  logic [3:0] idx, idx_n;
  logic [7:0] tcnt, tcnt_n;
  logic [7:0] score_n;
  logic [1:0] lives_n;
  logic [3:0] len_n;
  logic       wr_en;
  logic [3:0] events;
  logic [2:0] evt_code;
  logic [1:0] cur_move;
  logic       last_idx;
  logic       evt_ok;
  logic [8:0] score_sum;

  assign events    = {mouse_evt, mic_evt, push_evt, toggle_evt};
  assign last_idx  = (idx == round_len - 4'd1);
  assign score_sum = {1'b0, score} + {5'd0, round_len};
  assign evt_ok    = $onehot(events) && (evt_code == ({1'b0, cur_move} + 3'd1));

  always_comb begin
    cur_move = 2'd0;
    for (int i = 0; i < MAX_LEN; i++)
      if (idx == 4'(i)) cur_move = pattern[i];
  end

  always_comb begin
    evt_code = PR_NONE;
    if (toggle_evt)      evt_code = PR_TOGGLE;
    else if (push_evt)   evt_code = PR_PUSH;
    else if (mic_evt)    evt_code = PR_MIC;
    else if (mouse_evt)  evt_code = PR_MOUSE;
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    tcnt_n    = tcnt;
    score_n   = score;
    lives_n   = lives;
    len_n     = round_len;
    lfsr_n    = lfsr;
    wr_en     = 1'b0;
    prompt    = PR_NONE;
    listening = 1'b0;
    game_over = 1'b0;
    unique case (state)
      IDLE, OVER: begin
        game_over = (state == OVER);
        if (start) begin
          score_n = 8'd0;
          lives_n = 2'(LIVES);
          len_n   = 4'(START_LEN);
          idx_n   = 4'd0;
          tcnt_n  = 8'd0;
          state_n = GEN;
        end
      end
      GEN: begin
        lfsr_n = lfsr_step(lfsr);
        wr_en  = 1'b1;
        if (last_idx) begin
          idx_n   = 4'd0;
          tcnt_n  = 8'd0;
          state_n = SHOW_ON;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      SHOW_ON: begin
        prompt = {1'b0, cur_move} + 3'd1;
        if (tick) begin
          if (tcnt == 8'(SHOW_TICKS - 1)) begin
            tcnt_n  = 8'd0;
            state_n = SHOW_OFF;
          end else begin
            tcnt_n = tcnt + 8'd1;
          end
        end
      end
      SHOW_OFF: begin
        if (tick) begin
          tcnt_n = 8'd0;
          if (last_idx) begin
            idx_n   = 4'd0;
            state_n = LISTEN;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = SHOW_ON;
          end
        end
      end
      LISTEN: begin
        listening = 1'b1;
        // any event outranks a coincident tick, so a late answer is never timed out
        if (events != 4'd0) begin
          tcnt_n = 8'd0;
          if (!evt_ok) begin
            lives_n = lives - 2'd1;
            state_n = LOSE;
          end else if (last_idx) begin
            score_n = score_sum[8] ? 8'hFF : score_sum[7:0];
            len_n   = (round_len >= 4'(MAX_LEN)) ? 4'(MAX_LEN) : round_len + 4'd1;
            idx_n   = 4'd0;
            state_n = WIN;
          end else begin
            idx_n = idx + 4'd1;
          end
        end else if (tick) begin
          if (tcnt == 8'(TIMEOUT_TICKS - 1)) begin
            tcnt_n  = 8'd0;
            lives_n = lives - 2'd1;
            state_n = LOSE;
          end else begin
            tcnt_n = tcnt + 8'd1;
          end
        end
      end
      WIN, LOSE: begin
        prompt = (state == WIN) ? PR_WIN : PR_LOSE;
        if (tick) begin
          if (tcnt == 8'(FB_TICKS - 1)) begin
            tcnt_n  = 8'd0;
            idx_n   = 4'd0;
            state_n = (state == LOSE && lives == 2'd0) ? OVER : GEN;
          end else begin
            tcnt_n = tcnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      idx       <= 4'd0;
      tcnt      <= 8'd0;
      score     <= 8'd0;
      lives     <= 2'd0;
      round_len <= 4'd0;
      for (int i = 0; i < MAX_LEN; i++) pattern[i] <= 2'd0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      idx       <= idx_n;
      tcnt      <= tcnt_n;
      score     <= score_n;
      lives     <= lives_n;
      round_len <= len_n;
      if (wr_en)
        for (int i = 0; i < MAX_LEN; i++)
          if (idx == 4'(i)) pattern[i] <= lfsr_n[1:0];
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - directed self-checking bench for round_sequencer
module tb_round_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       toggle_evt = 1'b0;
  logic       push_evt = 1'b0;
  logic       mic_evt = 1'b0;
  logic       mouse_evt = 1'b0;
  logic [2:0] prompt;
  logic [7:0] score;
  logic [1:0] lives;
  logic [3:0] round_len;
  logic       listening;
  logic       game_over;

  int total = 0;
  int bad   = 0;
  int cyc;

  logic [7:0] m_lfsr = 8'hA5;
  int m_score = 0;
  int m_lives = 0;
  int m_len   = 0;
  int m_pat[$];
  int seen[$];

  round_sequencer #(
    .MAX_LEN(8), .START_LEN(2), .LIVES(3), .TICK_DIV(4),
    .SHOW_TICKS(2), .TIMEOUT_TICKS(8), .FB_TICKS(2), .SEED(8'hA5)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .toggle_evt(toggle_evt), .push_evt(push_evt), .mic_evt(mic_evt), .mouse_evt(mouse_evt),
    .prompt(prompt), .score(score), .lives(lives), .round_len(round_len),
    .listening(listening), .game_over(game_over)
  );

  always #5 clock = ~clock;

  // clocks since reset release; equals the prescaler phase modulo TICK_DIV
  always @(posedge clock or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  function automatic string q2s(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  task automatic drive_evt(input logic [3:0] ev);
    @(negedge clock);
    {mouse_evt, mic_evt, push_evt, toggle_evt} = ev;
    @(negedge clock);
    {mouse_evt, mic_evt, push_evt, toggle_evt} = 4'b0000;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic model_gen();
    m_pat.delete();
    for (int i = 0; i < m_len; i++) begin
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      m_pat.push_back(int'(m_lfsr[1:0]) + 1);
    end
  endtask

  task automatic check_show(input string name);
    int  prev;
    bit  reached;
    bit  mism;
    prev = 0;
    reached = 0;
    model_gen();
    seen.delete();
    for (int c = 0; c < 3000 && !reached; c++) begin
      @(negedge clock);
      if (listening) reached = 1;
      else begin
        if (prompt >= 3'd1 && prompt <= 3'd4 && int'(prompt) != prev) seen.push_back(int'(prompt));
        prev = int'(prompt);
      end
    end
    mism = !reached || (seen.size() != m_pat.size());
    for (int i = 0; i < seen.size() && i < m_pat.size(); i++)
      if (seen[i] != m_pat[i]) mism = 1;
    total++;
    if (mism) begin
      bad++;
      $display("FAIL %s playback: got [%s] listening=%0d, required [%s]", name, q2s(seen), reached, q2s(m_pat));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({prompt, score, lives, round_len, listening, game_over} !== 19'd0) begin
      bad++;
      $display("FAIL reset_state: got prompt=%0d score=%0d lives=%0d len=%0d lst=%0b over=%0b, required all 0",
               prompt, score, lives, round_len, listening, game_over);
    end
    reset = 1'b1;
    pulse_start();
    for (int c = 0; c < 60 && prompt == 3'd0; c++) @(negedge clock);
    total++;
    if (prompt == 3'd0) begin
      bad++;
      $display("FAIL reach_show_on: got prompt=0, required nonzero");
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({prompt, score, lives, round_len, listening, game_over} !== 19'd0) begin
      bad++;
      $display("FAIL async_reset: got prompt=%0d score=%0d lives=%0d len=%0d, required all 0",
               prompt, score, lives, round_len);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    m_lfsr = 8'hA5;
    m_score = 0;
    m_lives = 0;
    m_len = 0;
  endtask

  task automatic test_first_playback();
    int exp_pr;
    while (cyc % 4 != 1) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    m_score = 0;
    m_lives = 3;
    m_len = 2;
    model_gen();
    total++;
    if (score !== 8'd0 || lives !== 2'd3 || round_len !== 4'd2) begin
      bad++;
      $display("FAIL start_values: got score=%0d lives=%0d len=%0d, required 0 3 2", score, lives, round_len);
    end
    // SEED A5 -> lfsr 4A (move 3) -> 95 (move 2)
    for (int i = 0; i < 26; i++) begin
      if (i < 2)       exp_pr = 0;
      else if (i < 10) exp_pr = 3;
      else if (i < 14) exp_pr = 0;
      else if (i < 22) exp_pr = 2;
      else             exp_pr = 0;
      total++;
      if (prompt !== 3'(exp_pr) || listening !== 1'b0) begin
        bad++;
        $display("FAIL first_show[%0d]: got prompt=%0d lst=%0b, required prompt=%0d lst=0", i, prompt, listening, exp_pr);
      end
      @(negedge clock);
    end
    total++;
    if (listening !== 1'b1) begin
      bad++;
      $display("FAIL enter_listen: got listening=%0b, required 1", listening);
    end
  endtask

  task automatic test_win();
    drive_evt(4'b0100);
    while (cyc % 4 != 3) @(negedge clock);
    push_evt = 1'b1;
    @(negedge clock);
    push_evt = 1'b0;
    m_score = 2;
    m_len = 3;
    total++;
    if (score !== 8'd2 || round_len !== 4'd3) begin
      bad++;
      $display("FAIL win_update: got score=%0d len=%0d, required 2 3", score, round_len);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (prompt !== 3'd5) begin
        bad++;
        $display("FAIL win_prompt[%0d]: got %0d, required 5", i, prompt);
      end
      @(negedge clock);
    end
    total++;
    if (prompt !== 3'd0) begin
      bad++;
      $display("FAIL win_end: got %0d, required 0", prompt);
    end
    check_show("round3");
  endtask

  task automatic test_ignored_start();
    pulse_start();
    total++;
    if (listening !== 1'b1 || round_len !== 4'(m_len) || score !== 8'(m_score)) begin
      bad++;
      $display("FAIL ignored_start: got lst=%0b len=%0d score=%0d, required 1 %0d %0d",
               listening, round_len, score, m_len, m_score);
    end
  endtask

  task automatic test_double_event();
    drive_evt(4'b0011);
    m_lives--;
    total++;
    if (prompt !== 3'd6 || lives !== 2'(m_lives)) begin
      bad++;
      $display("FAIL double_evt_lose: got prompt=%0d lives=%0d, required 6 %0d", prompt, lives, m_lives);
    end
    total++;
    if (round_len !== 4'(m_len)) begin
      bad++;
      $display("FAIL lose_len_kept: got %0d, required %0d", round_len, m_len);
    end
    check_show("after_double");
  endtask

  task automatic test_timeout(input bool_show_next);
    int cnt;
    cnt = 1;
    for (int c = 0; c < 100 && listening; c++) begin
      @(negedge clock);
      if (listening) cnt++;
    end
    m_lives--;
    total++;
    if (cnt < 29 || cnt > 32) begin
      bad++;
      $display("FAIL timeout_len: got %0d cycles listening, required 29..32", cnt);
    end
    total++;
    if (prompt !== 3'd6 || lives !== 2'(m_lives)) begin
      bad++;
      $display("FAIL timeout_lose: got prompt=%0d lives=%0d, required 6 %0d", prompt, lives, m_lives);
    end
    if (bool_show_next) check_show("after_timeout");
  endtask

  task automatic test_game_over();
    for (int c = 0; c < 30 && !game_over; c++) @(negedge clock);
    total++;
    if (game_over !== 1'b1 || lives !== 2'd0 || prompt !== 3'd0) begin
      bad++;
      $display("FAIL game_over: got over=%0b lives=%0d prompt=%0d, required 1 0 0", game_over, lives, prompt);
    end
    drive_evt(4'b0001);
    total++;
    if (game_over !== 1'b1 || prompt !== 3'd0 || score !== 8'(m_score) || lives !== 2'd0) begin
      bad++;
      $display("FAIL over_ignores_evt: got over=%0b prompt=%0d score=%0d lives=%0d, required 1 0 %0d 0",
               game_over, prompt, score, lives, m_score);
    end
    pulse_start();
    m_score = 0;
    m_lives = 3;
    m_len = 2;
    total++;
    if (score !== 8'd0 || lives !== 2'd3 || round_len !== 4'd2 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL restart: got score=%0d lives=%0d len=%0d over=%0b, required 0 3 2 0",
               score, lives, round_len, game_over);
    end
  endtask

  task automatic play_round_win();
    logic [3:0] ev;
    check_show("win_round");
    foreach (m_pat[i]) begin
      ev = 4'(1 << (m_pat[i] - 1));
      drive_evt(ev);
    end
    m_score = (m_score + m_len > 255) ? 255 : m_score + m_len;
    m_len = (m_len < 8) ? m_len + 1 : 8;
    total++;
    if (prompt !== 3'd5 || score !== 8'(m_score) || round_len !== 4'(m_len)) begin
      bad++;
      $display("FAIL round_win: got prompt=%0d score=%0d len=%0d, required 5 %0d %0d",
               prompt, score, round_len, m_score, m_len);
    end
  endtask

  task automatic test_saturation();
    int bad0;
    bad0 = bad;
    for (int r = 0; r < 40 && m_score < 255 && bad == bad0; r++) play_round_win();
    if (bad == bad0) play_round_win();
    total++;
    if (score !== 8'd255 || round_len !== 4'd8) begin
      bad++;
      $display("FAIL saturate: got score=%0d len=%0d, required 255 8", score, round_len);
    end
  endtask

  initial begin
    test_reset();
    test_first_playback();
    test_win();
    test_ignored_start();
    test_double_event();
    test_timeout(1'b1);
    test_timeout(1'b0);
    test_game_over();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
